ps2_key_tracker: RTL
====================

Name: ps2_key_tracker

Overview:
- Sits between the PS/2 byte receiver and the frequency/controller stages of the piano.
- Consumes the raw scancode byte stream (one-cycle flag plus data byte) and tracks make (0xXX), break (F0 XX) and extended (E0 ...) sequences.
- Keeps a last-pressed-priority stack of held piano keys.
- Outputs the note index that should currently sound: 0 means silence. Key-press and key-release event pulses are also provided.

Parameters:
- DEPTH, 4, number of simultaneously held keys tracked (legal range 2..8).
- TIMEOUT, 2_000_000, clock cycles a prefix state (after E0 or F0) may wait for its next byte before it is abandoned. 20 ms at 100 MHz.

Ports:
- iClk  in  1  system clock.
- iReset_n  in  1  asynchronous active-low reset.
- iFlag  in  1  one-cycle strobe: iData holds a received byte.
- iData  in  8  scancode byte, valid when iFlag=1.
- oNote  out  8  current note index: 0 = silence, 1..21 = note.
- oNoteValid  out  1  high when oNote != 0.
- oPress  out  1  one-cycle pulse when a new key is pushed on the stack.
- oRelease  out  1  one-cycle pulse when a key is removed from the stack.
- oOverflow  out  1  one-cycle pulse when a push evicts the oldest entry.

Behaviour:
Interface:
- One clock, iClk.
- Reset iReset_n is asynchronous and active-low.
- All state is cleared on reset: FSM=IDLE, stack empty, timeout counter 0.
- Reset values of all outputs: oNote=0, oNoteValid=0, oPress=0, oRelease=0, oOverflow=0.
- Reset asserted mid-sequence discards any pending prefix and empties the stack.

Key map (make code -> note):
- Low row: 1C,1B,23,2B,34,33,3B -> 1..7.
- Mid row: 15,1D,24,2D,2C,35,3C -> 8..14.
- High row: 1A,22,21,2A,32,31,3A -> 15..21.
- Every other code is unmapped.

FSM states: IDLE, BRK (seen F0), EXT (seen E0), EXTBRK (seen E0 F0).
- IDLE:
  - byte E0 -> EXT.
  - byte F0 -> BRK.
  - mapped code -> push.
  - unmapped code -> ignored, stay IDLE.
- BRK: any byte -> release of that code (if mapped), then -> IDLE.
- EXT: F0 -> EXTBRK; any other byte -> ignored, -> IDLE.
- EXTBRK: any byte -> ignored, -> IDLE.
- Timeout:
  - The counter runs in BRK/EXT/EXTBRK and resets on every iFlag.
  - When it reaches TIMEOUT-1 the FSM returns to IDLE with no stack change.

Stack (entry 0 = most recent):
- Push when the note is already held (typematic repeat): no change, no pulse.
- Push when not held: shift entries down and insert at 0; oPress=1.
- Push while the stack is full: the oldest entry (DEPTH-1) is discarded; oPress=1 and oOverflow=1 in the same cycle.
- Release of a held note: remove it and compact the entries below it upward; oRelease=1.
- Release of a note not held: ignored, no pulse.

Timing:
- oNote = entry 0 note, or 0 if the stack is empty.
- oNote and the pulses are registered and update on the cycle after the iFlag cycle (latency 1).
- An iFlag arriving on consecutive cycles is accepted every cycle.

Optional Feature:
- Macro: KEY_TRACKER_SUSTAIN_EN.
- Enabled: adds input port iSustain (1 bit).
  - While iSustain=1, a release of a held note marks the entry "pending" instead of removing it. oRelease is not pulsed and oNote is unchanged.
  - On the falling edge of iSustain (registered), all pending entries are removed in one cycle, with compaction. oRelease pulses once if any were removed.
  - A re-press of a pending note clears its pending mark and moves it to entry 0; oPress=1.
- Disabled: no iSustain port; releases take effect immediately as above.

Test Plan:
1. Reset, then byte 1C -> one cycle later oNote=1, oNoteValid=1, oPress pulse. Then F0,1C -> oNote=0, oRelease pulse.
2. Press 1C then 15 -> oNote=8. Release 15 -> oNote=1. Release 1C -> oNote=0.
3. DEPTH=4: press 1C,1B,23,2B,34 -> 5th press gives oOverflow=1 and oNote=5. Release 34,2B,23,1B in turn -> oNote steps 4,3,2, then 0 (note 1 was evicted). Release 1C -> no pulse.
4. Typematic: press 1C three times -> single oPress; one F0,1C -> oNote=0.
5. Sequences E0,1C and E0,F0,1C, plus unmapped 76 -> no output change, FSM back in IDLE. F0 followed by no byte for TIMEOUT cycles -> IDLE; a subsequent 1C is treated as a press (oNote=1).
6. With KEY_TRACKER_SUSTAIN_EN: iSustain=1, press 1C, F0 1C -> oNote stays 1. Drop iSustain -> next cycle oNote=0, one oRelease pulse. Also assert iReset_n=0 mid-F0 -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// ps2_key_tracker : PS/2 scancode parser feeding a last-pressed-priority stack
//                   of held piano keys. Optional sustain: KEY_TRACKER_SUSTAIN_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module ps2_key_tracker #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iFlag,
  input  logic [7:0] iData,
`ifdef KEY_TRACKER_SUSTAIN_EN
  input  logic       iSustain,
`endif
  output logic [7:0] oNote,
  output logic       oNoteValid,
  output logic       oPress,
  output logic       oRelease,
  output logic       oOverflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_BRK    = 2'd1;
  localparam logic [1:0] c_EXT    = 2'd2;
  localparam logic [1:0] c_EXTBRK = 2'd3;
  localparam logic [IW-1:0] c_LAST = IW'(DEPTH - 1);
  localparam logic [CW-1:0] c_TMAX = CW'(TIMEOUT - 1);

  function automatic logic [4:0] keyToNote(input logic [7:0] code);
    case (code)
      8'h1C: keyToNote = 5'd1;   8'h1B: keyToNote = 5'd2;   8'h23: keyToNote = 5'd3;
      8'h2B: keyToNote = 5'd4;   8'h34: keyToNote = 5'd5;   8'h33: keyToNote = 5'd6;
      8'h3B: keyToNote = 5'd7;   8'h15: keyToNote = 5'd8;   8'h1D: keyToNote = 5'd9;
      8'h24: keyToNote = 5'd10;  8'h2D: keyToNote = 5'd11;  8'h2C: keyToNote = 5'd12;
      8'h35: keyToNote = 5'd13;  8'h3C: keyToNote = 5'd14;  8'h1A: keyToNote = 5'd15;
      8'h22: keyToNote = 5'd16;  8'h21: keyToNote = 5'd17;  8'h2A: keyToNote = 5'd18;
      8'h32: keyToNote = 5'd19;  8'h31: keyToNote = 5'd20;  8'h3A: keyToNote = 5'd21;
      default: keyToNote = 5'd0;
    endcase
  endfunction

  logic [1:0]    r_state, w_nextState;
  logic [CW-1:0] r_tmoCnt;
  logic          w_timeout, w_doPush, w_doRelease;
  logic [4:0]    w_code;
  logic          w_sustain, w_sustainFall;

  logic [4:0]    r_stack [DEPTH];
  logic          r_pend  [DEPTH];
  logic [4:0]    w_fStack [DEPTH], w_nStack [DEPTH];
  logic          w_fPend  [DEPTH], w_nPend  [DEPTH];
  logic          w_flushed, w_hit, w_press, w_release, w_overflow;
  logic [IW-1:0] w_hitIdx, w_rmIdx, w_wp;
  logic          r_press, r_release, r_overflow;

`ifdef KEY_TRACKER_SUSTAIN_EN
  logic r_sustainD;
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_sustainD <= 1'b0;
    else           r_sustainD <= iSustain;
  end
  assign w_sustain     = iSustain;
  assign w_sustainFall = r_sustainD & ~iSustain;
`else
  assign w_sustain     = 1'b0;
  assign w_sustainFall = 1'b0;
`endif

  assign w_code    = keyToNote(iData);
  assign w_timeout = (r_state != c_IDLE) && !iFlag && (r_tmoCnt == c_TMAX);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_state <= c_IDLE;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (iFlag) begin
      case (r_state)
        c_IDLE: begin
          if (iData == 8'hE0)      w_nextState = c_EXT;
          else if (iData == 8'hF0) w_nextState = c_BRK;
        end
        c_EXT:   w_nextState = (iData == 8'hF0) ? c_EXTBRK : c_IDLE;
        default: w_nextState = c_IDLE;
      endcase
    end else if (w_timeout) begin
      w_nextState = c_IDLE;
    end
  end

  always_comb begin
    w_doPush    = iFlag && (r_state == c_IDLE) && (w_code != 5'd0);
    w_doRelease = iFlag && (r_state == c_BRK)  && (w_code != 5'd0);
  end

  // Restarts on every byte so a slow but live sequence is never abandoned.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)                                    r_tmoCnt <= '0;
    else if (r_state == c_IDLE || iFlag || w_timeout) r_tmoCnt <= '0;
    else                                              r_tmoCnt <= r_tmoCnt + 1'b1;
  end

  // Pedal-up flush is applied first, then the current byte acts on the result.
  always_comb begin
    w_fStack  = r_stack;
    w_fPend   = r_pend;
    w_flushed = 1'b0;
    w_wp      = '0;
    if (w_sustainFall) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_fStack[i] = '0;
        w_fPend[i]  = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (r_pend[i]) begin
          w_flushed = 1'b1;
        end else if (r_stack[i] != 5'd0) begin
          w_fStack[w_wp] = r_stack[i];
          w_wp           = w_wp + 1'b1;
        end
      end
    end

    w_hit    = 1'b0;
    w_hitIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_hit && w_fStack[i] != 5'd0 && w_fStack[i] == w_code) begin
        w_hit    = 1'b1;
        w_hitIdx = IW'(i);
      end
    end

    w_nStack   = w_fStack;
    w_nPend    = w_fPend;
    w_press    = 1'b0;
    w_release  = w_flushed;
    w_overflow = 1'b0;
    w_rmIdx    = w_hit ? w_hitIdx : c_LAST;
    if (w_doPush) begin
      if (!w_hit || w_fPend[w_hitIdx]) begin
        w_press     = 1'b1;
        w_overflow  = !w_hit && (w_fStack[DEPTH-1] != 5'd0);
        w_nStack[0] = w_code;
        w_nPend[0]  = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
          if (i <= int'(w_rmIdx)) begin
            w_nStack[i] = w_fStack[i-1];
            w_nPend[i]  = w_fPend[i-1];
          end
        end
      end
    end else if (w_doRelease && w_hit) begin
      if (w_sustain) begin
        w_nPend[w_hitIdx] = 1'b1;
      end else begin
        w_release = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i >= int'(w_hitIdx)) begin
            w_nStack[i] = w_fStack[i+1];
            w_nPend[i]  = w_fPend[i+1];
          end
        end
        w_nStack[DEPTH-1] = '0;
        w_nPend[DEPTH-1]  = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stack[i] <= '0;
        r_pend[i]  <= 1'b0;
      end
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_stack    <= w_nStack;
      r_pend     <= w_nPend;
      r_press    <= w_press;
      r_release  <= w_release;
      r_overflow <= w_overflow;
    end
  end

  assign oNote      = {3'b000, r_stack[0]};
  assign oNoteValid = (r_stack[0] != 5'd0);
  assign oPress     = r_press;
  assign oRelease   = r_release;
  assign oOverflow  = r_overflow;

endmodule

`default_nettype wire
